// File: rtl/timestamp_event_assembler.sv
// ----------------------------------------------------------------------------
// timestamp_event_assembler
//
// Drains the first-word-fall-through FIFO of the timestamp core, reassembles
// each 3-word record into one 64-bit timestamp and offers it on a valid/ready
// stream. Every popped word has its identifier and index checked. Protocol
// errors are counted in a saturating counter for the readout/trigger logic.
//
// Upstream word layout: [31:28] identifier, [27:24] index (0,1,2),
// [23:0] payload. TS = {w0[15:0], w1[23:0], w2[23:0]}.
//
// Ports
//   BUS_CLK     in   1          clock
//   BUS_RST     in   1          asynchronous active-high reset
//   ENABLE      in   1          1 = drain the FIFO, 0 = hold (partial record kept)
//   FIFO_EMPTY  in   1          upstream FIFO empty
//   FIFO_DATA   in   32         upstream head word, valid while FIFO_EMPTY=0
//   FIFO_READ   out  1          pop strobe (combinational), one word per cycle
//   TS_VALID    out  1          assembled timestamp available
//   TS_READY    in   1          consumer accepts on TS_VALID & TS_READY
//   TS_DATA     out  64         assembled timestamp, stable while TS_VALID=1
//   ERR_COUNT   out  ERR_WIDTH  saturating protocol-error counter
//   ERR_CLR     in   1          synchronous clear of ERR_COUNT (wins over +1)
// ----------------------------------------------------------------------------
module timestamp_event_assembler #(
    parameter logic [3:0]  IDENTIFIER = 4'b0001,
    parameter int unsigned ERR_WIDTH  = 8
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic                 ENABLE,
    input  logic                 FIFO_EMPTY,
    input  logic [31:0]          FIFO_DATA,
    output logic                 FIFO_READ,
    output logic                 TS_VALID,
    input  logic                 TS_READY,
    output logic [63:0]          TS_DATA,
    output logic [ERR_WIDTH-1:0] ERR_COUNT,
    input  logic                 ERR_CLR
);

    localparam int unsigned PAY_W  = 24;
    localparam int unsigned W0_W   = 16;
    localparam int unsigned TS_W   = 64;
    localparam int unsigned IDX_W  = 4;

    localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;

    // W0/W1/W2 encodings double as the index expected in that state
    typedef enum logic [1:0] {
        S_W0  = 2'd0,
        S_W1  = 2'd1,
        S_W2  = 2'd2,
        S_OUT = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [W0_W-1:0]        r_w0;
    logic [PAY_W-1:0]       r_w1;
    logic [TS_W-1:0]        r_ts_data;
    logic                   r_ts_valid;
    logic [ERR_WIDTH-1:0]   r_err_count;

    // Word decode
    logic [3:0]             w_id;
    logic [IDX_W-1:0]       w_idx;
    logic [PAY_W-1:0]       w_payload;
    logic [IDX_W-1:0]       w_idx_exp;
    logic                   w_id_ok;
    logic                   w_idx_ok;
    logic                   w_idx_zero;
    logic                   w_pop;

    // Output-decode strobes
    logic                   w_err;
    logic                   w_ld_w0;
    logic                   w_ld_w1;
    logic                   w_ld_ts;
    logic                   w_ts_ack;

    assign w_id       = FIFO_DATA[31:28];
    assign w_idx      = FIFO_DATA[27:24];
    assign w_payload  = FIFO_DATA[23:0];
    assign w_idx_exp  = IDX_W'(r_state);
    assign w_id_ok    = (w_id == IDENTIFIER);
    assign w_idx_ok   = (w_idx == w_idx_exp);
    assign w_idx_zero = (w_idx == '0);

    // Pop only while collecting words; reset forces the strobe low
    assign w_pop = ENABLE & ~FIFO_EMPTY & ~BUS_RST & (r_state != S_OUT);

    // State register
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            r_state <= S_W0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_OUT: begin
                if (TS_READY) begin
                    w_state_nxt = S_W0;
                end
            end
            default: begin
                if (w_pop && w_id_ok) begin
                    if (w_idx_ok) begin
                        case (r_state)
                            S_W0:    w_state_nxt = S_W1;
                            S_W1:    w_state_nxt = S_W2;
                            default: w_state_nxt = S_OUT;
                        endcase
                    end else if (w_idx_zero) begin
                        // Unexpected start of a new record: restart with it as w0
                        w_state_nxt = S_W1;
                    end else begin
                        w_state_nxt = S_W0;
                    end
                end
                // A bad identifier is dropped without touching the state
            end
        endcase
    end

    // Output decode
    always_comb begin
        FIFO_READ = 1'b0;
        w_err     = 1'b0;
        w_ld_w0   = 1'b0;
        w_ld_w1   = 1'b0;
        w_ld_ts   = 1'b0;
        w_ts_ack  = 1'b0;
        if (r_state == S_OUT) begin
            w_ts_ack = TS_READY;
        end else if (w_pop) begin
            FIFO_READ = 1'b1;
            w_err     = ~w_id_ok | ~w_idx_ok;
            // Index 0 is either the expected w0 or a restart; both store it
            w_ld_w0   = w_id_ok & w_idx_zero;
            w_ld_w1   = w_id_ok & w_idx_ok & (r_state == S_W1);
            w_ld_ts   = w_id_ok & w_idx_ok & (r_state == S_W2);
        end
    end

    // Partial-record registers
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            r_w0 <= '0;
            r_w1 <= '0;
        end else begin
            if (w_ld_w0) begin
                r_w0 <= w_payload[W0_W-1:0];
            end
            if (w_ld_w1) begin
                r_w1 <= w_payload;
            end
        end
    end

    // Output timestamp and its valid flag
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            r_ts_data  <= '0;
            r_ts_valid <= 1'b0;
        end else begin
            if (w_ld_ts) begin
                r_ts_data  <= {r_w0, r_w1, w_payload};
                r_ts_valid <= 1'b1;
            end else if (w_ts_ack) begin
                r_ts_valid <= 1'b0;
            end
        end
    end

    // Saturating error counter; clear wins over a same-cycle error
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            r_err_count <= '0;
        end else if (ERR_CLR) begin
            r_err_count <= '0;
        end else if (w_err && (r_err_count != ERR_MAX)) begin
            r_err_count <= r_err_count + ERR_WIDTH'(1);
        end
    end

    assign TS_VALID  = r_ts_valid;
    assign TS_DATA   = r_ts_data;
    assign ERR_COUNT = r_err_count;

endmodule
